stage_mem: RTL

//  Memory-access stage of the 5-stage RV32 pipeline; consumer of the EX-stage MCR/WDR/ASR/RAR/F3R registers.

---
 rtl/stage_mem_pkg.sv | 22 ++
 rtl/stage_mem_if.sv | 24 ++
 rtl/stage_mem_load_ext.sv | 39 +++
 rtl/stage_mem.sv | 133 +++++++++++++
 4 files changed

// File: rtl/stage_mem_pkg.sv
// Shared definitions for the MEM stage: MCR bit positions, funct3 load encodings, FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package stage_mem_pkg;

    // MCR = {MemW, MemR, Write_strb[3:0]}
    localparam int MCR_MEMW = 5;
    localparam int MCR_MEMR = 4;

    // funct3 load encodings
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [0:0] {
        MEM_IDLE    = 1'b0,
        MEM_RD_WAIT = 1'b1
    } mem_state_t;

endpackage

// File: rtl/stage_mem_if.sv
// Memory request/response bus between the MEM stage (master) and the data memory (slave).
// Latency: n/a (wires only).
// Backpressure: request held until Mem_Req_Ready; read data held until Read_data_Ready.
interface stage_mem_if;
    logic [31:0] Address;
    logic        MemWrite;
    logic        MemRead;
    logic [31:0] Write_data;
    logic [3:0]  Write_strb;
    logic        Mem_Req_Ready;
    logic [31:0] Read_data;
    logic        Read_data_Valid;
    logic        Read_data_Ready;

    modport master (
        output Address, MemWrite, MemRead, Write_data, Write_strb, Read_data_Ready,
        input  Mem_Req_Ready, Read_data, Read_data_Valid
    );

    modport slave (
        input  Address, MemWrite, MemRead, Write_data, Write_strb, Read_data_Ready,
        output Mem_Req_Ready, Read_data, Read_data_Valid
    );
endinterface

// File: rtl/stage_mem_load_ext.sv
// Load lane select and sign/zero extension: rdata, lane (addr[1:0]), f3 -> 32-bit result.
// Latency: combinational.
// Backpressure: none.
module stage_mem_load_ext
    import stage_mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  lane,
    input  logic [2:0]  f3,
    output logic [31:0] result
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = rdata[7:0];
        case (lane)
            2'd0: byte_v = rdata[7:0];
            2'd1: byte_v = rdata[15:8];
            2'd2: byte_v = rdata[23:16];
            2'd3: byte_v = rdata[31:24];
            default: byte_v = rdata[7:0];
        endcase
        // halfwords are naturally aligned, so only lane[1] picks the half
        half_v = lane[1] ? rdata[31:16] : rdata[15:0];

        result = rdata;
        case (f3)
            F3_LB:   result = {{24{byte_v[7]}}, byte_v};
            F3_LH:   result = {{16{half_v[15]}}, half_v};
            F3_LW:   result = rdata;
            F3_LBU:  result = {24'd0, byte_v};
            F3_LHU:  result = {16'd0, half_v};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/stage_mem.sv
// RV32 memory-access stage: issues loads/stores, aligns load data, registers results for WB.
// Latency: ALU op 1 cycle; store 1 cycle after accept; load 1 cycle after Read_data_Valid.
// Backpressure: Feedback_Mem_Acc freezes EX while a request or read response is outstanding.
// Optional: MEM_PERF_CNT_EN enables load/store/stall counters (ports read 0 otherwise).
// Ports: clk/rst, EX inputs (Done_I, PC_I, MCR, WDR, ASR, RAR, F3R), mem bus (master),
//        WB outputs (Done_O, PC_O, RF_waddr_O, RF_wen_O, RF_wdata_O), Perf_* counters.
module stage_mem
    import stage_mem_pkg::*;
#(
    parameter int PERF_CNT_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  Done_I,
    input  logic [31:0]           PC_I,
    input  logic [5:0]            MCR,
    input  logic [31:0]           WDR,
    input  logic [31:0]           ASR,
    input  logic [4:0]            RAR,
    input  logic [2:0]            F3R,
    output logic                  Feedback_Mem_Acc,
    stage_mem_if.master           mem,
    output logic                  Done_O,
    output logic [31:0]           PC_O,
    output logic [4:0]            RF_waddr_O,
    output logic                  RF_wen_O,
    output logic [31:0]           RF_wdata_O,
    output logic [PERF_CNT_W-1:0] Perf_load_cnt,
    output logic [PERF_CNT_W-1:0] Perf_store_cnt,
    output logic [PERF_CNT_W-1:0] Perf_stall_cnt
);

    mem_state_t  state, state_nxt;
    logic        is_st, is_ld;
    logic        mem_wr, mem_rd, rd_rdy, fb;
    logic        complete;
    logic [31:0] ld_result;

    // store wins when both MemW and MemR are set
    assign is_st = Done_I & MCR[MCR_MEMW];
    assign is_ld = Done_I & MCR[MCR_MEMR] & ~MCR[MCR_MEMW];

    always_comb begin
        state_nxt = state;
        mem_wr    = 1'b0;
        mem_rd    = 1'b0;
        rd_rdy    = 1'b0;
        fb        = 1'b0;
        case (state)
            MEM_IDLE: begin
                if (is_st) begin
                    mem_wr = 1'b1;
                    fb     = ~mem.Mem_Req_Ready;
                end else if (is_ld) begin
                    mem_rd = 1'b1;
                    fb     = 1'b1;
                    if (mem.Mem_Req_Ready) state_nxt = MEM_RD_WAIT;
                end
            end
            MEM_RD_WAIT: begin
                rd_rdy = 1'b1;
                fb     = ~mem.Read_data_Valid;
                if (mem.Read_data_Valid) state_nxt = MEM_IDLE;
            end
            default: state_nxt = MEM_IDLE;
        endcase
    end

    // reset masks the handshake outputs so nothing is issued or accepted while rst is high
    assign mem.MemWrite        = mem_wr & ~rst;
    assign mem.MemRead         = mem_rd & ~rst;
    assign mem.Read_data_Ready = rd_rdy & ~rst;
    assign mem.Address         = {ASR[31:2], 2'b00};
    assign mem.Write_data      = WDR;
    assign mem.Write_strb      = MCR[3:0];
    assign Feedback_Mem_Acc    = fb;

    // EX advances on the same edge that completes the instruction here
    assign complete = Done_I & ~fb;

    stage_mem_load_ext u_load_ext (
        .rdata  (mem.Read_data),
        .lane   (ASR[1:0]),
        .f3     (F3R),
        .result (ld_result)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= MEM_IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            Done_O     <= 1'b0;
            PC_O       <= 32'd0;
            RF_waddr_O <= 5'd0;
            RF_wdata_O <= 32'd0;
        end else begin
            Done_O <= complete;
            if (complete) begin
                PC_O       <= PC_I;
                RF_waddr_O <= RAR;
                RF_wdata_O <= (state == MEM_RD_WAIT) ? ld_result : ASR;
            end
        end
    end

    assign RF_wen_O = Done_O & (RF_waddr_O != 5'd0);

`ifdef MEM_PERF_CNT_EN
    logic ld_done, st_acc;
    assign ld_done = (state == MEM_RD_WAIT) & mem.Read_data_Valid;
    assign st_acc  = mem_wr & mem.Mem_Req_Ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            Perf_load_cnt  <= '0;
            Perf_store_cnt <= '0;
            Perf_stall_cnt <= '0;
        end else begin
            if (ld_done) Perf_load_cnt  <= Perf_load_cnt + 1'b1;
            if (st_acc)  Perf_store_cnt <= Perf_store_cnt + 1'b1;
            if (fb)      Perf_stall_cnt <= Perf_stall_cnt + 1'b1;
        end
    end
`else
    assign Perf_load_cnt  = '0;
    assign Perf_store_cnt = '0;
    assign Perf_stall_cnt = '0;
`endif

endmodule
